input_port_buffer: RTL and testbench

- Requester side of the router's switch arbitration: one instance per router input port.
- Receives flits from the link with credit flow control and buffers them in a first-word-fall-through FIFO.
- Raises a routing request for each packet header, waits for the grant from switch control, then streams the whole packet (header, size, payload) to the crossbar.
- Releases the request path at packet end.

---
 rtl/phoenix_pkg.sv | 19 +
 rtl/flit_fifo.sv | 54 +++++
 rtl/input_port_buffer.sv | 113 +++++++++++
 tb/tb_input_port_buffer.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/phoenix_pkg.sv
// Constants and types shared by the router blocks: default flit geometry,
// packet field positions and the input-port FSM encoding.
package phoenix_pkg;

  localparam int FLIT_WIDTH_DEF = 16;
  localparam int DEPTH_DEF      = 16;

  localparam int HEADER_IDX = 0;
  localparam int SIZE_IDX   = 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    REQ       = 3'd1,
    SEND_HDR  = 3'd2,
    SEND_SIZE = 3'd3,
    SEND_BODY = 3'd4
  } state_t;

endpackage

// File: rtl/flit_fifo.sv
// First-word-fall-through flit FIFO; dout shows the head flit and reads 0 when
// empty. Pushes while full and pops while empty are ignored.
module flit_fifo #(
  parameter int FLIT_WIDTH = 16,
  parameter int DEPTH      = 16,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [FLIT_WIDTH-1:0] din,
  output logic [FLIT_WIDTH-1:0] dout,
  output logic [AW:0]           count,
  output logic                  full,
  output logic                  empty
);

  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [FLIT_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Pointers are exactly AW bits wide, so wrap modulo DEPTH is free.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/input_port_buffer.sv
// Router input port: buffers link flits under credit flow control, requests the
// switch for each header and streams the granted packet to the crossbar.
module input_port_buffer
  import phoenix_pkg::*;
#(
  parameter int FLIT_WIDTH = FLIT_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rx,
  input  logic [FLIT_WIDTH-1:0] data_in,
  output logic                  credit_o,
  output logic                  h,
  input  logic                  ack_h,
  output logic                  data_av,
  output logic [FLIT_WIDTH-1:0] data_out,
  input  logic                  data_ack,
  output logic                  sender,
  output state_t                state_dbg
);

  localparam int AW = $clog2(DEPTH);

  // Handshake: a flit moves to the crossbar on a cycle where data_av and
  // data_ack are both high; data_ack with data_av low has no effect.

  state_t                state;
  state_t                state_next;
  logic [FLIT_WIDTH-1:0] flit_cnt;
  logic [FLIT_WIDTH-1:0] flit_cnt_next;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  empty;
  logic [AW:0]           count;

  assign credit_o  = !full;
  assign push      = rx && credit_o;
  assign state_dbg = state;

  flit_fifo #(
    .FLIT_WIDTH (FLIT_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (data_in),
    .dout  (data_out),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      flit_cnt <= '0;
    end else begin
      state    <= state_next;
      flit_cnt <= flit_cnt_next;
    end
  end

  always_comb begin
    state_next    = state;
    flit_cnt_next = flit_cnt;
    h             = 1'b0;
    data_av       = 1'b0;
    sender        = 1'b0;
    pop           = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) state_next = REQ;
      end
      REQ: begin
        h = 1'b1;
        if (ack_h) state_next = SEND_HDR;
      end
      SEND_HDR: begin
        sender  = 1'b1;
        data_av = !empty;
        if (data_ack && !empty) begin
          pop        = 1'b1;
          state_next = SEND_SIZE;
        end
      end
      SEND_SIZE: begin
        sender  = 1'b1;
        data_av = !empty;
        if (data_ack && !empty) begin
          pop           = 1'b1;
          flit_cnt_next = data_out;
          // A zero-size packet ends with its size flit.
          state_next    = (data_out == '0) ? IDLE : SEND_BODY;
        end
      end
      SEND_BODY: begin
        sender  = 1'b1;
        data_av = !empty;
        if (data_ack && !empty) begin
          pop           = 1'b1;
          flit_cnt_next = flit_cnt - 1'b1;
          if (flit_cnt == FLIT_WIDTH'(1)) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_input_port_buffer.sv
// Bench for input_port_buffer: directed scenarios plus random traffic checked
// against a packet-level reference model of the port.
module tb_input_port_buffer;
  import phoenix_pkg::*;

  localparam int W     = 16;
  localparam int DEPTH = 16;

  logic         clock = 1'b0;
  logic         reset, rx, ack_h, data_ack;
  logic [W-1:0] data_in;
  logic         credit_o, h, data_av, sender;
  logic [W-1:0] data_out;
  state_t       state_dbg;

  input_port_buffer #(.FLIT_WIDTH(W), .DEPTH(DEPTH)) dut (
    .clock    (clock),
    .reset    (reset),
    .rx       (rx),
    .data_in  (data_in),
    .credit_o (credit_o),
    .h        (h),
    .ack_h    (ack_h),
    .data_av  (data_av),
    .data_out (data_out),
    .data_ack (data_ack),
    .sender   (sender),
    .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Reference model: exp_q holds accepted flits in order; m_phase is
  // 0 = no request, 1 = requesting, 2 = streaming a granted packet.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] push_q[$];
  logic [W-1:0] popped_q[$];
  logic [W-1:0] want_q[$];
  int           m_phase = 0, m_idx = 0, m_total = 0, m_size = 0, stall_seen = 0;
  bit           mon_en = 1'b0;
  bit           e_credit, e_h, e_av, e_sender;
  logic [W-1:0] e_dout, f;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Monitor: compares outputs to the model mid-cycle, then advances the model
  // over the coming rising edge using the inputs now held stable.
  initial forever begin
    @(negedge clock);
    if (mon_en) begin
      e_credit = (exp_q.size() != DEPTH);
      e_dout   = (exp_q.size() != 0) ? exp_q[0] : '0;
      e_h      = (m_phase == 1);
      e_sender = (m_phase == 2);
      e_av     = e_sender && (exp_q.size() != 0);
      checks += 5;
      if (credit_o !== e_credit) begin failures++; $display("FAIL mon_credit t=%0t got=%b exp=%b", $time, credit_o, e_credit); end
      if (h !== e_h)             begin failures++; $display("FAIL mon_h t=%0t got=%b exp=%b", $time, h, e_h); end
      if (sender !== e_sender)   begin failures++; $display("FAIL mon_sender t=%0t got=%b exp=%b", $time, sender, e_sender); end
      if (data_av !== e_av)      begin failures++; $display("FAIL mon_data_av t=%0t got=%b exp=%b", $time, data_av, e_av); end
      if (data_out !== e_dout)   begin failures++; $display("FAIL mon_data_out t=%0t got=%h exp=%h", $time, data_out, e_dout); end
      if (data_av && data_ack) popped_q.push_back(data_out);
      if (reset) begin
        exp_q.delete();
        m_phase = 0; m_idx = 0; m_total = 0;
      end else begin
        if (e_sender && !e_av) stall_seen++;
        m_size = exp_q.size();
        if (m_phase == 0 && m_size != 0) m_phase = 1;
        else if (m_phase == 1 && ack_h) begin m_phase = 2; m_idx = 0; end
        else if (m_phase == 2 && e_av && data_ack) begin
          f = exp_q.pop_front();
          if (m_idx == 1) m_total = int'(f) + 2;
          m_idx++;
          if (m_idx >= 2 && m_idx == m_total) begin m_phase = 0; m_idx = 0; end
        end
        if (rx && e_credit) exp_q.push_back(data_in);
      end
    end
  end

  task automatic drive(input int gap_min, input int gap_max, input int ack_pct, input int budget);
    int gap = 0;
    int cyc = 0;
    bit acc;
    while ((push_q.size() != 0 || m_phase != 0 || exp_q.size() != 0) && cyc < budget) begin
      rx       = (push_q.size() != 0 && gap == 0);
      data_in  = rx ? push_q[0] : '0;
      ack_h    = h && ($urandom_range(0, 99) < 70);
      data_ack = ($urandom_range(0, 99) < ack_pct);
      acc      = rx && credit_o;
      step();
      cyc++;
      if (acc) begin void'(push_q.pop_front()); gap = $urandom_range(gap_min, gap_max); end
      else if (gap > 0) gap--;
    end
    rx = 1'b0; ack_h = 1'b0; data_ack = 1'b0;
    checks++;
    if (push_q.size() != 0 || m_phase != 0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL drive_timeout cycles=%0d left_to_push=%0d buffered=%0d required=all drained", cyc, push_q.size(), exp_q.size());
    end
  endtask

  task automatic wait_h(input int budget);
    int n = 0;
    while (!h && n < budget) begin step(); n++; end
    checks++;
    if (h !== 1'b1) begin failures++; $display("FAIL wait_h got=%b exp=1 after %0d cycles", h, n); end
  endtask

  task automatic push_now(input logic [W-1:0] v);
    rx = 1'b1; data_in = v;
    step();
    rx = 1'b0; data_in = '0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      checks += 5;
      if (h !== 1'b0)        begin failures++; $display("FAIL reset_h got=%b exp=0", h); end
      if (data_av !== 1'b0)  begin failures++; $display("FAIL reset_data_av got=%b exp=0", data_av); end
      if (sender !== 1'b0)   begin failures++; $display("FAIL reset_sender got=%b exp=0", sender); end
      if (credit_o !== 1'b1) begin failures++; $display("FAIL reset_credit got=%b exp=1", credit_o); end
      if (data_out !== '0)   begin failures++; $display("FAIL reset_data_out got=%h exp=0", data_out); end
      step();
    end
  endtask

  task automatic test_single();
    logic [W-1:0] pkt[5] = '{16'h0012, 16'h0003, 16'h00A1, 16'h00A2, 16'h00A3};
    popped_q.delete();
    for (int i = 0; i < 5; i++) push_q.push_back(pkt[i]);
    drive(0, 0, 100, 200);
    checks++;
    if (popped_q.size() != 5) begin failures++; $display("FAIL single_pops got=%0d exp=5", popped_q.size()); end
    for (int i = 0; i < 5 && i < popped_q.size(); i++) begin
      checks++;
      if (popped_q[i] !== pkt[i]) begin failures++; $display("FAIL single_flit%0d got=%h exp=%h", i, popped_q[i], pkt[i]); end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (h !== 1'b0 || sender !== 1'b0) begin failures++; $display("FAIL single_quiet h=%b sender=%b exp=0,0", h, sender); end
      step();
    end
  endtask

  task automatic test_zero_size();
    popped_q.delete();
    data_ack = 1'b0;
    push_now(16'h0021); push_now(16'h0000); push_now(16'h0031);
    wait_h(10);
    ack_h = 1'b1; step(); ack_h = 1'b0;
    checks++;
    if (sender !== 1'b1 || data_av !== 1'b1) begin failures++; $display("FAIL zero_grant sender=%b data_av=%b exp=1,1", sender, data_av); end
    data_ack = 1'b1; step(); step(); data_ack = 1'b0;
    checks++;
    if (sender !== 1'b0 || h !== 1'b0) begin failures++; $display("FAIL zero_idle sender=%b h=%b exp=0,0", sender, h); end
    step();
    checks++;
    if (h !== 1'b1) begin failures++; $display("FAIL zero_next_h got=%b exp=1", h); end
    checks++;
    if (popped_q.size() != 2 || popped_q[0] !== 16'h0021 || popped_q[1] !== 16'h0000) begin
      failures++; $display("FAIL zero_pops got_count=%0d exp=2 (0021,0000)", popped_q.size());
    end
    push_q.push_back(16'h0000);
    drive(0, 0, 100, 100);
    checks++;
    if (popped_q.size() != 4 || popped_q[2] !== 16'h0031) begin failures++; $display("FAIL zero_second got_count=%0d exp=4", popped_q.size()); end
  endtask

  task automatic test_full();
    logic [W-1:0] fl[17];
    popped_q.delete();
    fl[0] = W'($urandom); fl[1] = 16'd14;
    for (int i = 2; i < 17; i++) fl[i] = W'($urandom);
    data_ack = 1'b0;
    for (int i = 0; i < 17; i++) begin
      push_now(fl[i]);
      checks++;
      if (credit_o !== (i < 15)) begin failures++; $display("FAIL full_credit push=%0d got=%b exp=%b", i + 1, credit_o, (i < 15)); end
    end
    checks++;
    if (h !== 1'b1) begin failures++; $display("FAIL full_h got=%b exp=1", h); end
    ack_h = 1'b1; step(); ack_h = 1'b0;
    checks++;
    if (credit_o !== 1'b0) begin failures++; $display("FAIL full_hold got=%b exp=0", credit_o); end
    data_ack = 1'b1; step(); data_ack = 1'b0;
    checks++;
    if (credit_o !== 1'b1) begin failures++; $display("FAIL full_release got=%b exp=1", credit_o); end
    drive(0, 0, 80, 400);
    checks++;
    if (popped_q.size() != 16 || popped_q[0] !== fl[0] || popped_q[15] !== fl[15]) begin
      failures++; $display("FAIL full_drop got_count=%0d exp=16", popped_q.size());
    end
  endtask

  task automatic test_stall();
    int bad = 0;
    popped_q.delete(); want_q.delete();
    stall_seen = 0;
    want_q.push_back(W'($urandom)); want_q.push_back(16'd4);
    for (int i = 0; i < 4; i++) want_q.push_back(W'($urandom));
    push_q = want_q;
    drive(3, 3, 100, 300);
    checks++;
    if (stall_seen == 0) begin failures++; $display("FAIL stall_seen got=0 exp>0"); end
    for (int i = 0; i < want_q.size(); i++)
      if (i >= popped_q.size() || popped_q[i] !== want_q[i]) bad++;
    checks++;
    if (bad != 0 || popped_q.size() != 6) begin failures++; $display("FAIL stall_stream bad=%0d count=%0d exp=0,6", bad, popped_q.size()); end
  endtask

  task automatic test_simultaneous();
    int bad = 0;
    bit acc;
    popped_q.delete(); want_q.delete();
    want_q.push_back(W'($urandom)); want_q.push_back(16'd30);
    for (int i = 0; i < 30; i++) want_q.push_back(W'($urandom));
    push_q = want_q;
    data_ack = 1'b0;
    for (int i = 0; i < 16; i++) push_now(push_q.pop_front());
    checks++;
    if (credit_o !== 1'b0 || h !== 1'b1) begin failures++; $display("FAIL simul_fill credit=%b h=%b exp=0,1", credit_o, h); end
    ack_h = 1'b1; step(); ack_h = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rx = 1'b1; data_in = push_q[0]; data_ack = 1'b1;
      acc = credit_o;
      step();
      if (acc) void'(push_q.pop_front());
      checks++;
      if (credit_o !== 1'b1 || data_av !== 1'b1) begin failures++; $display("FAIL simul_level cycle=%0d credit=%b data_av=%b exp=1,1", i, credit_o, data_av); end
    end
    rx = 1'b0; data_ack = 1'b0;
    drive(0, 2, 70, 1000);
    for (int i = 0; i < want_q.size(); i++)
      if (i >= popped_q.size() || popped_q[i] !== want_q[i]) bad++;
    checks++;
    if (bad != 0 || popped_q.size() != 32) begin failures++; $display("FAIL simul_stream bad=%0d count=%0d exp=0,32", bad, popped_q.size()); end
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    push_now(W'($urandom)); push_now(16'd5);
    for (int i = 0; i < 5; i++) push_now(W'($urandom));
    wait_h(10);
    ack_h = 1'b1; step(); ack_h = 1'b0;
    data_ack = 1'b1;
    for (int i = 0; i < 4; i++) step();
    data_ack = 1'b0; reset = 1'b1; step(); reset = 1'b0;
    checks += 5;
    if (h !== 1'b0)        begin failures++; $display("FAIL mid_h got=%b exp=0", h); end
    if (data_av !== 1'b0)  begin failures++; $display("FAIL mid_data_av got=%b exp=0", data_av); end
    if (sender !== 1'b0)   begin failures++; $display("FAIL mid_sender got=%b exp=0", sender); end
    if (credit_o !== 1'b1) begin failures++; $display("FAIL mid_credit got=%b exp=1", credit_o); end
    if (data_out !== '0)   begin failures++; $display("FAIL mid_data_out got=%h exp=0", data_out); end
    popped_q.delete(); want_q.delete();
    want_q.push_back(W'($urandom)); want_q.push_back(16'd2);
    want_q.push_back(W'($urandom)); want_q.push_back(W'($urandom));
    push_q = want_q;
    drive(0, 1, 70, 200);
    for (int i = 0; i < 4; i++)
      if (i >= popped_q.size() || popped_q[i] !== want_q[i]) bad++;
    checks++;
    if (bad != 0 || popped_q.size() != 4) begin failures++; $display("FAIL mid_recover bad=%0d count=%0d exp=0,4", bad, popped_q.size()); end
  endtask

  task automatic test_random();
    int bad = 0;
    int n;
    popped_q.delete(); want_q.delete();
    for (int p = 0; p < 6; p++) begin
      n = $urandom_range(0, 5);
      want_q.push_back(W'($urandom));
      want_q.push_back(W'(n));
      for (int i = 0; i < n; i++) want_q.push_back(W'($urandom));
    end
    push_q = want_q;
    drive(0, 2, 60, 2000);
    for (int i = 0; i < want_q.size(); i++)
      if (i >= popped_q.size() || popped_q[i] !== want_q[i]) bad++;
    checks++;
    if (bad != 0 || popped_q.size() != want_q.size()) begin
      failures++; $display("FAIL random_stream bad=%0d count=%0d exp=0,%0d", bad, popped_q.size(), want_q.size());
    end
  endtask

  initial begin
    reset = 1'b1; rx = 1'b0; ack_h = 1'b0; data_ack = 1'b0; data_in = '0;
    step(); step();
    reset = 1'b0;
    mon_en = 1'b1;
    test_reset();
    test_single();
    test_zero_size();
    test_full();
    test_stall();
    test_simultaneous();
    test_reset_mid();
    test_random();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
